regfile_sb: RTL and testbench

Parametrised successor to the processor's 32x32 two-read-port register file. It generalises data width, register count and read-port count, and adds optional same-cycle write-to-read bypass. It also adds a pending-write scoreboard so that multicycle units (mult/div, later a load queue) can mark a destination busy at issue and clear it on writeback. It sits between the processor pipeline and the writeback stage, in the slot the current regfile occupies.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/regfile_sb.sv | 79 +++++++
 tb/tb_regfile_sb.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and packed-bus helpers for the parametrised register file
// and its pending-write scoreboard.
package regfile_pkg;

    localparam int DATA_WIDTH_D = 32;
    localparam int ADDR_WIDTH_D = 5;
    localparam int NUM_READ_MAX = 4;
    localparam int ZERO_REG     = 0;

    // Read ports are packed side by side; port p starts at p*width.
    function automatic int portLsb(input int port, input int width);
        return port * width;
    endfunction

    function automatic int numRegs(input int addrWidth);
        return 2 ** addrWidth;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at multicycle issue
// and cleared by the matching writeback, with per-read-port busy flags.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_D,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           set_i,
    input  logic [ADDR_WIDTH-1:0]          setReg_i,
    input  logic                           clr_i,
    input  logic [ADDR_WIDTH-1:0]          clrReg_i,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] readReg_i,
    output logic [(2**ADDR_WIDTH)-1:0]     busyVec_o,
    output logic [NUM_READ-1:0]            readBusy_o,
    output logic                           anyBusy_o
);

    localparam int NREGS = numRegs(ADDR_WIDTH);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Set is applied after clear so a reissue to the completing destination stays busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clrReg_i] = 1'b0;
        end
        if (set_i) begin
            busy_d[setReg_i] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : gReadBusy
        logic [ADDR_WIDTH-1:0] rIdx;
        logic                  releasing;

        assign rIdx      = readReg_i[portLsb(p, ADDR_WIDTH) +: ADDR_WIDTH];
        assign releasing = (BYPASS != 0) && clr_i && (clrReg_i == rIdx);
        assign readBusy_o[p] = busy_q[rIdx] && !releasing;
    end

    assign busyVec_o = busy_q;
    assign anyBusy_o = |busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Flip-flop register file with asynchronous multi-port reads, optional
// write-to-read bypass, hardwired zero register and a pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int ADDR_WIDTH = ADDR_WIDTH_D,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]          data_writeReg,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
    input  logic                           busy_set,
    input  logic [ADDR_WIDTH-1:0]          busy_setReg,
    output logic [NUM_READ-1:0]            read_busy,
    output logic [(2**ADDR_WIDTH)-1:0]     busy_vec,
    output logic                           any_busy
);

    localparam int NREGS = numRegs(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic                  writeValid;

    assign writeValid = ctrl_writeEnable && (ctrl_writeReg != ADDR_WIDTH'(ZERO_REG));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (writeValid) begin
            regs_q[ctrl_writeReg] <= data_writeReg;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : gRead
        logic [ADDR_WIDTH-1:0] rIdx;
        logic [DATA_WIDTH-1:0] rData;

        assign rIdx = ctrl_readReg[portLsb(p, ADDR_WIDTH) +: ADDR_WIDTH];

        // Reset and the zero register override the bypass path as well.
        always_comb begin
            rData = regs_q[rIdx];
            if ((BYPASS != 0) && writeValid && (ctrl_writeReg == rIdx)) begin
                rData = data_writeReg;
            end
            if (reset || (rIdx == ADDR_WIDTH'(ZERO_REG))) begin
                rData = '0;
            end
        end

        assign data_readReg[portLsb(p, DATA_WIDTH) +: DATA_WIDTH] = rData;
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_READ   (NUM_READ),
        .BYPASS     (BYPASS)
    ) uScoreboard (
        .clock      (clock),
        .reset      (reset),
        .set_i      (busy_set),
        .setReg_i   (busy_setReg),
        .clr_i      (ctrl_writeEnable),
        .clrReg_i   (ctrl_writeReg),
        .readReg_i  (ctrl_readReg),
        .busyVec_o  (busy_vec),
        .readBusy_o (read_busy),
        .anyBusy_o  (any_busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a bypassing and a non-bypassing instance share stimulus
// and are compared against an array/bit-vector model of the register file.
module tb_regfile_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NREGS = 32;

    logic clock = 1'b0;
    logic reset;

    logic              we;
    logic [AW-1:0]     wr;
    logic [DW-1:0]     wd;
    logic [NR*AW-1:0]  rdIdx;
    logic              bs;
    logic [AW-1:0]     bsr;

    logic [NR*DW-1:0]  dataByp, dataNb;
    logic [NR-1:0]     rbByp, rbNb;
    logic [NREGS-1:0]  bvByp, bvNb;
    logic              anyByp, anyNb;

    int testsRun  = 0;
    int failCount = 0;

    logic [DW-1:0]    modelRegs [NREGS];
    logic [NREGS-1:0] modelBusy;

    always #5 clock = ~clock;

    regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(1)) dut (
        .clock(clock), .reset(reset),
        .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wd),
        .ctrl_readReg(rdIdx), .data_readReg(dataByp),
        .busy_set(bs), .busy_setReg(bsr),
        .read_busy(rbByp), .busy_vec(bvByp), .any_busy(anyByp)
    );

    regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(0)) dutNb (
        .clock(clock), .reset(reset),
        .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wd),
        .ctrl_readReg(rdIdx), .data_readReg(dataNb),
        .busy_set(bs), .busy_setReg(bsr),
        .read_busy(rbNb), .busy_vec(bvNb), .any_busy(anyNb)
    );

    task automatic clearModel();
        for (int i = 0; i < NREGS; i++) begin
            modelRegs[i] = '0;
        end
        modelBusy = '0;
    endtask

    task automatic checkValue(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic weV, input logic [AW-1:0] wrV, input logic [DW-1:0] wdV,
                                 input logic bsV, input logic [AW-1:0] bsrV,
                                 input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        we    = weV;
        wr    = wrV;
        wd    = wdV;
        bs    = bsV;
        bsr   = bsrV;
        rdIdx = {r1, r0};
    endtask

    // Expected outputs come straight from the model: stored value, optionally
    // overridden by the in-flight write on the bypassing instance.
    task automatic checkOutput(input string step);
        logic [AW-1:0] idx;
        logic          hit;
        logic [DW-1:0] expData;
        logic [DW-1:0] obsData;
        logic          expRb;
        logic          obsRb;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NR; p++) begin
                idx = rdIdx[p*AW +: AW];
                hit = (d == 0) && we && (wr == idx);
                if (reset || idx == 0)
                    expData = '0;
                else if (hit)
                    expData = wd;
                else
                    expData = modelRegs[idx];
                expRb   = !reset && modelBusy[idx] && !hit;
                obsData = (d == 0) ? dataByp[p*DW +: DW] : dataNb[p*DW +: DW];
                obsRb   = (d == 0) ? rbByp[p] : rbNb[p];
                checkValue($sformatf("%s byp%0d data p%0d r%0d", step, 1 - d, p, idx), obsData, expData);
                checkValue($sformatf("%s byp%0d read_busy p%0d r%0d", step, 1 - d, p, idx),
                           {31'b0, obsRb}, {31'b0, expRb});
            end
            checkValue($sformatf("%s byp%0d busy_vec", step, 1 - d),
                       (d == 0) ? bvByp : bvNb, reset ? '0 : modelBusy);
            checkValue($sformatf("%s byp%0d any_busy", step, 1 - d),
                       {31'b0, (d == 0) ? anyByp : anyNb}, {31'b0, !reset && (|modelBusy)});
        end
    endtask

    // Advances one clock edge and applies the write and scoreboard rules to the model.
    task automatic tick();
        @(posedge clock);
        if (!reset) begin
            for (int i = 1; i < NREGS; i++) begin
                if (bs && int'(bsr) == i)
                    modelBusy[i] = 1'b1;
                else if (we && int'(wr) == i)
                    modelBusy[i] = 1'b0;
            end
            if (we && wr != 0)
                modelRegs[wr] = wd;
        end
        #2;
    endtask

    task automatic cycle(input string step, input logic weV, input logic [AW-1:0] wrV,
                         input logic [DW-1:0] wdV, input logic bsV, input logic [AW-1:0] bsrV,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        applyStimulus(weV, wrV, wdV, bsV, bsrV, r0, r1);
        #1;
        checkOutput(step);
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] idxA;
        logic [AW-1:0] idxB;

        reset = 1'b1;
        clearModel();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0);

        // Reads under reset, including a concurrent write that must not bypass.
        for (int i = 0; i < NREGS; i++) begin
            @(negedge clock);
            applyStimulus(1'b1, AW'(i), $urandom, 1'b1, AW'(i), AW'(i), AW'(NREGS - 1 - i));
            #1;
            checkOutput("reset");
        end
        @(negedge clock);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #2;

        cycle("write r5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd5, 5'd0);
        cycle("after r5", 1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd5);

        cycle("write r0", 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0);
        cycle("after r0", 1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd0);

        cycle("set r7", 1'b0, '0, '0, 1'b1, 5'd7, 5'd0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            cycle("idle r7", 1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd7);
        end
        cycle("wb r7", 1'b1, 5'd7, 32'h00000042, 1'b0, '0, 5'd0, 5'd7);
        cycle("after r7", 1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd7);

        cycle("set r9", 1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
        cycle("set+wb r9", 1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9, 5'd9, 5'd9);
        cycle("after r9", 1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9);
        cycle("wb r9", 1'b1, 5'd9, 32'h00000077, 1'b0, '0, 5'd9, 5'd0);

        // Mid-cycle reset with r3 holding data and marked busy.
        cycle("write r3", 1'b1, 5'd3, 32'h00000055, 1'b1, 5'd3, 5'd3, 5'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd3);
        #1;
        checkOutput("r3 held");
        #1;
        reset = 1'b1;
        clearModel();
        #1;
        checkOutput("async reset");
        #1;
        reset = 1'b0;
        tick();

        for (int n = 0; n < 400; n++) begin
            idxA = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            idxB = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            cycle("random", ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 7)), idxA, idxB);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
